// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared types for the UART RX frame controller: FSM states, error codes, default header byte.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_OUT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_LEN     = 2'b01,
        ERR_CSUM    = 2'b10,
        ERR_TIMEOUT = 2'b11
    } err_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_fifo_byte_reader.sv
// RX FIFO read port driver: issues one RD_REQ pulse at a time and captures D the cycle after it.
module uart_fifo_byte_reader (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_want,
    input  logic       i_empty,
    input  logic [7:0] i_d,
    output logic       o_rd_req,
    output logic       o_byte_vld,
    output logic [7:0] o_byte
);

    logic       r_rd_req;
    logic       r_pend;
    logic       r_byte_vld;
    logic [7:0] r_byte;

    // r_pend marks the cycle in which the FIFO presents D for the previous request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_req   <= 1'b0;
            r_pend     <= 1'b0;
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
        end else begin
            r_rd_req   <= i_want && !i_empty && !r_rd_req && !r_pend;
            r_pend     <= r_rd_req;
            r_byte_vld <= r_pend;
            if (r_pend) begin
                r_byte <= i_d;
            end
        end
    end

    assign o_rd_req   = r_rd_req;
    assign o_byte_vld = r_byte_vld;
    assign o_byte     = r_byte;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: hunts HEADER/LEN/payload/CSUM frames, buffers and streams good payloads.
// Optional inter-byte timeout is enabled by defining RX_TIMEOUT_EN.
module uart_rx_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       SYS_CLK,
    input  logic       RST,
    input  logic       EMPTY_SIG,
    output logic       RD_REQ,
    input  logic [7:0] D,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic       OUT_LAST,
    output logic       FRAME_OK,
    output logic       FRAME_ERR,
    output logic [1:0] ERR_CODE,
    output logic       BUSY
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t           r_state;
    logic [IDX_W-1:0] r_len;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [7:0]       r_sum;
    logic [7:0]       r_buf [MAX_LEN];
    logic [7:0]       r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_frame_ok;
    logic             r_frame_err;
    err_t             r_err_code;

    logic             w_want;
    logic             w_byte_vld;
    logic [7:0]       w_byte;
    logic [IDX_W-1:0] w_rd_nxt;
    logic [IDX_W-1:0] w_len_m1;
    logic [IDX_W-1:0] w_idx_nxt;

    // No fetch while a byte is being consumed, so a CSUM byte can never leave a read in flight into OUT.
    assign w_want    = (r_state != S_OUT) && !w_byte_vld;
    assign w_rd_nxt  = r_rd_idx + 1'b1;
    assign w_len_m1  = r_len - 1'b1;
    assign w_idx_nxt = r_idx + 1'b1;

    uart_fifo_byte_reader u_reader (
        .i_clk      (SYS_CLK),
        .i_rst      (RST),
        .i_want     (w_want),
        .i_empty    (EMPTY_SIG),
        .i_d        (D),
        .o_rd_req   (RD_REQ),
        .o_byte_vld (w_byte_vld),
        .o_byte     (w_byte)
    );

`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_active;
    logic            w_timeout;

    assign w_to_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    assign w_timeout   = w_to_active && !w_byte_vld && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge SYS_CLK) begin
        if (RST || !w_to_active || w_byte_vld || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge SYS_CLK) begin
        if (r_state == S_PAYLOAD && w_byte_vld) begin
            r_buf[r_idx[AW-1:0]] <= w_byte;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            r_state     <= S_HUNT;
            r_len       <= '0;
            r_idx       <= '0;
            r_rd_idx    <= '0;
            r_sum       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_HUNT: begin
                    if (w_byte_vld && w_byte == HEADER) begin
                        r_state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_byte_vld) begin
                        if (w_byte == 8'h00 || w_byte > 8'(MAX_LEN)) begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_LEN;
                            r_state     <= S_HUNT;
                        end else begin
                            r_len   <= w_byte[IDX_W-1:0];
                            r_sum   <= w_byte;
                            r_idx   <= '0;
                            r_state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_byte_vld) begin
                        r_sum <= r_sum + w_byte;
                        r_idx <= w_idx_nxt;
                        if (w_idx_nxt == r_len) begin
                            r_state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (w_byte_vld) begin
                        if (8'(r_sum + w_byte) == 8'h00) begin
                            r_frame_ok <= 1'b1;
                            r_rd_idx   <= '0;
                            r_state    <= S_OUT;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_err_code  <= ERR_CSUM;
                            r_state     <= S_HUNT;
                        end
                    end
                end
                S_OUT: begin
                    // First OUT cycle (the FRAME_OK cycle) prefetches buf[0]; afterwards advance on handshake.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_buf[r_rd_idx[AW-1:0]];
                        r_out_last  <= (r_rd_idx == w_len_m1);
                    end else if (OUT_READY) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_state     <= S_HUNT;
                        end else begin
                            r_rd_idx   <= w_rd_nxt;
                            r_out_data <= r_buf[w_rd_nxt[AW-1:0]];
                            r_out_last <= (w_rd_nxt == w_len_m1);
                        end
                    end
                end
                default: r_state <= S_HUNT;
            endcase
`ifdef RX_TIMEOUT_EN
            if (w_timeout) begin
                r_frame_err <= 1'b1;
                r_err_code  <= ERR_TIMEOUT;
                r_state     <= S_HUNT;
            end
`endif
        end
    end

    assign OUT_DATA  = r_out_data;
    assign OUT_VALID = r_out_valid;
    assign OUT_LAST  = r_out_last;
    assign FRAME_OK  = r_frame_ok;
    assign FRAME_ERR = r_frame_err;
    assign ERR_CODE  = r_err_code;
    assign BUSY      = (r_state != S_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed vector table, hand sequences, randomized frames vs model.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         TO      = 300;
    localparam logic [7:0] HDR     = 8'hA5;

    logic       SYS_CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EMPTY_SIG = 1'b1;
    logic       RD_REQ;
    logic [7:0] D = 8'h00;
    logic [7:0] OUT_DATA;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b0;
    logic       OUT_LAST;
    logic       FRAME_OK;
    logic       FRAME_ERR;
    logic [1:0] ERR_CODE;
    logic       BUSY;

    uart_rx_frame_ctrl #(.HEADER(HDR), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
        .SYS_CLK(SYS_CLK), .RST(RST), .EMPTY_SIG(EMPTY_SIG), .RD_REQ(RD_REQ), .D(D),
        .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
        .FRAME_OK(FRAME_OK), .FRAME_ERR(FRAME_ERR), .ERR_CODE(ERR_CODE), .BUSY(BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int tests = 0;
    int fails = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] stream_q[$];
    int         obs_codes[$];
    logic [8:0] obs_pay[$];
    int         exp_codes[$];
    logic [8:0] exp_pay[$];
    bit         model_partial;

    int  rdy_mode = 0;
    bit  in_out = 0;
    bit  prev_v = 0, prev_hs = 0;
    logic [7:0] prev_d = 0;
    int  rd_in_out = 0, stab_err = 0, underflow = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO model, consumer and stream monitor all on the inactive edge.
    always @(negedge SYS_CLK) begin
        case (rdy_mode)
            0:       OUT_READY = 1'b1;
            1:       OUT_READY = 1'($urandom_range(0, 1));
            default: OUT_READY = 1'b0;
        endcase
        if (RST) begin
            in_out = 0;
            prev_v = 0;
        end else begin
            if (OUT_VALID && OUT_READY) obs_pay.push_back({OUT_LAST, OUT_DATA});
            if (FRAME_OK) begin
                obs_codes.push_back(0);
                in_out = 1;
            end
            if (FRAME_ERR) obs_codes.push_back(int'(ERR_CODE));
            if (RD_REQ && in_out) rd_in_out++;
            if (prev_v && !prev_hs && (!OUT_VALID || OUT_DATA != prev_d)) stab_err++;
            if (OUT_VALID && OUT_READY && OUT_LAST) in_out = 0;
            prev_v  = OUT_VALID;
            prev_hs = OUT_VALID && OUT_READY;
            prev_d  = OUT_DATA;
        end
        if (RD_REQ) begin
            if (fifo_q.size() > 0) D = fifo_q.pop_front();
            else underflow++;
        end
        EMPTY_SIG = (fifo_q.size() == 0);
    end

    // Reference: parse the whole byte stream by the frame rules.
    task automatic model_parse();
        int i, n, len;
        logic [7:0] s;
        exp_codes.delete();
        exp_pay.delete();
        model_partial = 0;
        i = 0;
        n = stream_q.size();
        while (i < n) begin
            if (stream_q[i] != HDR) begin
                i++;
            end else if (i + 1 >= n) begin
                model_partial = 1;
                i = n;
            end else begin
                len = int'(stream_q[i+1]);
                if (len == 0 || len > MAX_LEN) begin
                    exp_codes.push_back(1);
                    i += 2;
                end else if (i + 2 + len >= n) begin
                    model_partial = 1;
                    i = n;
                end else begin
                    s = 8'h00;
                    for (int k = 0; k <= len + 1; k++) s += stream_q[i+1+k];
                    if (s == 8'h00) begin
                        exp_codes.push_back(0);
                        for (int k = 0; k < len; k++) exp_pay.push_back({k == len - 1, stream_q[i+2+k]});
                    end else begin
                        exp_codes.push_back(2);
                    end
                    i += len + 3;
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        check($sformatf("%s.ncodes", tag), obs_codes.size(), exp_codes.size());
        n = (obs_codes.size() < exp_codes.size()) ? obs_codes.size() : exp_codes.size();
        for (int k = 0; k < n; k++) check($sformatf("%s.code%0d", tag, k), obs_codes[k], exp_codes[k]);
        check($sformatf("%s.npay", tag), obs_pay.size(), exp_pay.size());
        n = (obs_pay.size() < exp_pay.size()) ? obs_pay.size() : exp_pay.size();
        for (int k = 0; k < n; k++) check($sformatf("%s.pay%0d", tag, k), 32'(obs_pay[k]), 32'(exp_pay[k]));
    endtask

    task automatic do_reset();
        @(negedge SYS_CLK);
        RST = 1'b1;
        fifo_q.delete();
        stream_q.delete();
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        obs_codes.delete();
        obs_pay.delete();
        RST = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        stream_q.push_back(b);
    endtask

    task automatic wait_idle(input string name, input bit allow_busy);
        int quiet = 0, cyc = 0;
        while (quiet < 12 && cyc < 6000) begin
            @(negedge SYS_CLK);
            cyc++;
            if (fifo_q.size() == 0 && !OUT_VALID && !RD_REQ && (allow_busy || !BUSY)) quiet++;
            else quiet = 0;
        end
        check({name, ".idle_reached"}, quiet >= 12, 1);
    endtask

    task automatic gen_frame();
        int kind, len;
        logic [7:0] s, b;
        kind = $urandom_range(0, 5);
        if (kind <= 3) begin
            len = $urandom_range(1, MAX_LEN);
            push(HDR);
            push(8'(len));
            s = 8'(len);
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom_range(0, 255));
                push(b);
                s += b;
            end
            b = 8'h00 - s;
            if (kind == 3) b = b ^ 8'($urandom_range(1, 255));
            push(b);
        end else if (kind == 4) begin
            push(HDR);
            push(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
        end else begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) push(8'($urandom_range(0, 255)));
        end
    endtask

    typedef struct {
        logic [7:0][7:0] b;
        int              nb;
        int              n_ok;
        int              n_err;
        logic [1:0]      code;
        logic [3:0][7:0] pay;
        int              npay;
    } vec_t;

    function automatic logic [7:0][7:0] pk(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        return {a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    vec_t vecs[7];

    initial begin
        int cnt_ok, cnt_err, waitc, bad;

        vecs[0] = '{pk(8'hA5,8'h02,8'h11,8'h22,8'hCB,0,0,0), 5, 1, 0, 2'b00, {8'h0,8'h0,8'h22,8'h11}, 2};
        vecs[1] = '{pk(8'hA5,8'h02,8'h11,8'h22,8'hCC,0,0,0), 5, 0, 1, 2'b10, '0, 0};
        vecs[2] = '{pk(8'hA5,8'h00,0,0,0,0,0,0),             2, 0, 1, 2'b01, '0, 0};
        vecs[3] = '{pk(8'hA5,8'h11,8'hA5,8'h01,8'h07,8'hF8,0,0), 6, 1, 1, 2'b01, {24'h0,8'h07}, 1};
        vecs[4] = '{pk(8'h00,8'hFF,8'hA5,8'h01,8'hA5,8'h5A,0,0), 6, 1, 0, 2'b00, {24'h0,8'hA5}, 1};
        vecs[5] = '{pk(8'hA5,8'h01,8'h00,8'hFF,0,0,0,0),      4, 1, 0, 2'b00, '0, 1};
        vecs[6] = '{pk(8'hA5,8'h01,8'h10,8'h00,8'hA5,8'h01,8'h10,8'hEF), 8, 1, 1, 2'b10, {24'h0,8'h10}, 1};

        do_reset();
        @(negedge SYS_CLK);
        check("rst.RD_REQ", RD_REQ, 0);
        check("rst.OUT_VALID", OUT_VALID, 0);
        check("rst.OUT_DATA", OUT_DATA, 0);
        check("rst.OUT_LAST", OUT_LAST, 0);
        check("rst.FRAME_OK", FRAME_OK, 0);
        check("rst.FRAME_ERR", FRAME_ERR, 0);
        check("rst.ERR_CODE", ERR_CODE, 0);
        check("rst.BUSY", BUSY, 0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            rdy_mode = v % 2;
            for (int k = 0; k < vecs[v].nb; k++) push(vecs[v].b[k]);
            wait_idle($sformatf("vec%0d", v), 0);
            cnt_ok = 0;
            cnt_err = 0;
            foreach (obs_codes[k]) if (obs_codes[k] == 0) cnt_ok++; else cnt_err++;
            check($sformatf("vec%0d.n_ok", v), cnt_ok, vecs[v].n_ok);
            check($sformatf("vec%0d.n_err", v), cnt_err, vecs[v].n_err);
            check($sformatf("vec%0d.ERR_CODE", v), ERR_CODE, vecs[v].code);
            check($sformatf("vec%0d.npay", v), obs_pay.size(), vecs[v].npay);
            for (int k = 0; k < vecs[v].npay && k < obs_pay.size(); k++)
                check($sformatf("vec%0d.pay%0d", v, k), 32'(obs_pay[k]), 32'({k == vecs[v].npay - 1, vecs[v].pay[k]}));
            model_parse();
            compare_model($sformatf("vec%0d.model", v));
        end

        // Backpressure: hold OUT_READY low during playout, next frame must stay in the FIFO.
        do_reset();
        rdy_mode = 2;
        push(8'hA5); push(8'h02); push(8'h11); push(8'h22); push(8'hCB);
        push(8'hA5); push(8'h01); push(8'h00); push(8'hFF);
        waitc = 0;
        while (obs_codes.size() == 0 && waitc < 200) begin
            @(negedge SYS_CLK);
            waitc++;
        end
        check("bp.frame_ok_seen", obs_codes.size() > 0, 1);
        bad = 0;
        repeat (20) begin
            @(negedge SYS_CLK);
            if (!OUT_VALID || OUT_DATA != 8'h11 || OUT_LAST) bad++;
        end
        check("bp.held_cycles_bad", bad, 0);
        check("bp.fifo_preserved", fifo_q.size(), 4);
        rdy_mode = 0;
        wait_idle("bp", 0);
        model_parse();
        compare_model("bp.model");

        // Longest legal frame: LEN = MAX_LEN.
        do_reset();
        rdy_mode = 1;
        begin
            logic [7:0] s;
            push(HDR);
            push(8'(MAX_LEN));
            s = 8'(MAX_LEN);
            for (int k = 0; k < MAX_LEN; k++) begin
                push(8'(k * 7 + 3));
                s += 8'(k * 7 + 3);
            end
            push(8'h00 - s);
        end
        wait_idle("maxlen", 0);
        model_parse();
        check("maxlen.model_codes", exp_codes.size(), 1);
        compare_model("maxlen");

        // Stalled frame.
        do_reset();
        rdy_mode = 0;
        push(8'hA5); push(8'h03); push(8'h11);
        waitc = 0;
        while (fifo_q.size() != 0 && waitc < 100) begin
            @(negedge SYS_CLK);
            waitc++;
        end
`ifdef RX_TIMEOUT_EN
        waitc = 0;
        while (obs_codes.size() == 0 && waitc < TO + 100) begin
            @(negedge SYS_CLK);
            waitc++;
        end
        check("to.err_seen", obs_codes.size(), 1);
        check("to.code", (obs_codes.size() > 0) ? obs_codes[0] : -1, 3);
        check("to.delay_in_range", (waitc >= TO && waitc <= TO + 10), 1);
        @(negedge SYS_CLK);
        check("to.ERR_CODE", ERR_CODE, 2'b11);
        check("to.BUSY", BUSY, 0);
`else
        repeat (2 * TO) @(negedge SYS_CLK);
        check("stall.no_event", obs_codes.size(), 0);
        check("stall.BUSY", BUSY, 1);
        push(8'h22); push(8'h33); push(8'h97);
        wait_idle("stall", 0);
        check("stall.n_ok", obs_codes.size(), 1);
        check("stall.npay", obs_pay.size(), 3);
        if (obs_pay.size() == 3) check("stall.last", 32'(obs_pay[2]), 32'(9'h133));
`endif

        // Reset mid-PAYLOAD with a held error code.
        do_reset();
        push(8'hA5); push(8'h00);
        push(8'hA5); push(8'h04); push(8'h01); push(8'h02);
        wait_idle("midrst.pre", 1);
        check("midrst.pre_ERR_CODE", ERR_CODE, 2'b01);
        check("midrst.pre_BUSY", BUSY, 1);
        RST = 1'b1;
        @(negedge SYS_CLK);
        RST = 1'b0;
        check("midrst.BUSY", BUSY, 0);
        check("midrst.ERR_CODE", ERR_CODE, 0);
        check("midrst.OUT_VALID", OUT_VALID, 0);
        check("midrst.FRAME_ERR", FRAME_ERR, 0);
        check("midrst.FRAME_OK", FRAME_OK, 0);
        check("midrst.RD_REQ", RD_REQ, 0);
        obs_codes.delete();
        obs_pay.delete();
        stream_q.delete();
        push(8'h33); push(8'h44);
        push(8'hA5); push(8'h01); push(8'h5C); push(8'hA3);
        wait_idle("midrst.post", 0);
        model_parse();
        compare_model("midrst.post");

        for (int b = 0; b < 10; b++) begin
            do_reset();
            rdy_mode = b % 2;
            for (int f = 0; f < 6; f++) gen_frame();
            model_parse();
            wait_idle($sformatf("rnd%0d", b), model_partial);
            compare_model($sformatf("rnd%0d", b));
        end

        check("rd_req_during_out", rd_in_out, 0);
        check("stream_stability", stab_err, 0);
        check("fifo_underflow", underflow, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
